uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
Serial UART receiver and counterpart of the team's UART transmitter; it uses the same baud derivation and the same frame format. The frame format is idle-high, one start bit (0), package_size data bits LSB first, and one stop bit (1). The block synchronises the asynchronous rx line, detects the start edge, and samples each bit at its centre. It presents the parallel word with a one-cycle valid strobe or a one-cycle framing-error strobe. It sits between the board RX pin and downstream logic such as a command decoder or a loopback to uart_tx.

Parameters:
transfer_speed, 4800, baud rate in bits/s
package_size, 8, data bits per frame (1..16)
frequency, 27_000_000, clk frequency in Hz

Ports:
clk  input  1  system clock; all logic on posedge
rst  input  1  synchronous active-high reset
rx  input  1  asynchronous serial line, idle high
data  output  package_size  last correctly framed word
data_valid  output  1  one-cycle pulse; data updated this cycle
frame_error  output  1  one-cycle pulse; stop bit sampled 0
busy  output  1  high while not in IDLE

Behaviour:
- Constants: BIT_TICKS = frequency / transfer_speed (integer division). HALF_TICKS = BIT_TICKS / 2. The tick counter is wide enough for BIT_TICKS-1, i.e. $clog2(BIT_TICKS).
- Synchroniser: 2-FF on rx, reset value 1. All logic uses the synchronised rx_s, which adds 2 cycles of latency.
- Reset (rst=1 at posedge):
  - state = IDLE; counters = 0; shift register = 0.
  - data = 0, data_valid = 0, frame_error = 0, busy = 0.
  - Reset mid-frame aborts the frame with no strobe.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE:
  - rx_s == 0 -> START, tick counter = 0.
- START:
  - Count to HALF_TICKS-1, then sample.
  - rx_s == 0: valid start -> DATA, tick counter = 0, bit index = 0.
  - rx_s == 1: glitch -> IDLE. No strobe.
- DATA:
  - Count to BIT_TICKS-1, then sample at the bit centre.
  - Shift rx_s into the MSB of the shift register (right shift, LSB first on the wire).
  - After bit package_size-1 -> STOP.
- STOP:
  - Count to BIT_TICKS-1, then sample.
  - rx_s == 1: data <= shift register, data_valid = 1 for exactly one cycle -> IDLE. IDLE is re-entered at mid-stop, so a back-to-back frame start edge is caught.
  - rx_s == 0: frame_error = 1 for one cycle; data is unchanged -> WAIT_IDLE.
- WAIT_IDLE:
  - Stay until rx_s == 1, then -> IDLE. Break conditions therefore do not retrigger.
- data_valid and frame_error are never high in the same cycle; each is high for exactly one clk per frame.
- busy = (state != IDLE), registered.
- Latency: the data_valid cycle is sampled HALF_TICKS + package_size*BIT_TICKS + BIT_TICKS ±2 clk after the rx falling edge. The ±2 covers the synchroniser plus the sampling edge.
- Baud tolerance: combined transmitter/receiver error of ±3% or less must decode correctly.
- The data register holds its value between frames.

Decomposition:
- Shared package uart_pkg:
  - function bit_ticks(frequency, transfer_speed).
  - FSM state enum: IDLE, START, DATA, STOP, WAIT_IDLE.
  - Constants START_BIT = 0 and STOP_BIT = 1, also used by uart_tx.
- Natural sub-module: uart_sync2, the 2-FF synchroniser with reset value parameter.
- The baud counter stays inline.

Test Plan (frequency=1600, transfer_speed=100 -> BIT_TICKS=16, HALF_TICKS=8):
1. Reset, rx=1 idle for 200 cycles -> data=0, no strobes, busy=0.
2. Drive frame 0x A5 (bits 1,0,1,0,0,1,0,1 LSB first) at 16 clk/bit -> single data_valid pulse, data=8'hA5, frame_error=0, busy falls the same cycle.
3. Two frames 0x00 then 0xFF back-to-back with no idle gap -> two data_valid pulses 160 clk apart, data=8'h00 then 8'hFF.
4. rx low for 4 cycles only (glitch) -> return to IDLE after ~10 clk, no strobe; a following 0x3C frame decodes as 8'h3C.
5. Frame 0x55 with stop bit forced 0, rx held low 50 more cycles -> frame_error pulse, data keeps previous value, busy stays high until rx returns to 1. The next frame 0x12 decodes.
6. Assert rst during bit 4 of a frame -> all outputs 0 on the next cycle, no strobe. The tail of the interrupted frame must not produce data_valid; a clean 0x81 frame afterwards decodes correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: baud derivation, receiver FSM states and frame-level bit values.
// Imported by uart_rx and uart_tx so both ends agree on framing.
package uart_pkg;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } uart_state_t;

    function automatic int bit_ticks(input int frequency, input int transfer_speed);
        return frequency / transfer_speed;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for a single asynchronous input.
// The reset value lets an idle-high line stay quiet while the block is held in reset.
module uart_sync2 #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RESET_VALUE;
            r_sync <= RESET_VALUE;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: idle-high line, one start bit, package_size data bits LSB first, one stop bit.
// Each bit is sampled at its centre; a good frame pulses data_valid, a bad stop bit pulses frame_error.
module uart_rx
    import uart_pkg::*;
#(
    parameter int transfer_speed = 4800,
    parameter int package_size   = 8,
    parameter int frequency      = 27_000_000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rx,
    output logic [package_size-1:0] data,
    output logic                    data_valid,
    output logic                    frame_error,
    output logic                    busy
);

    localparam int BIT_TICKS  = bit_ticks(frequency, transfer_speed);
    localparam int HALF_TICKS = BIT_TICKS / 2;
    localparam int CNT_W      = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
    localparam int IDX_W      = (package_size > 1) ? $clog2(package_size) : 1;

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_TICKS - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_TICKS - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(package_size - 1);

    logic                    w_rx_s;
    uart_state_t             r_state;
    uart_state_t             w_state_nxt;
    logic [CNT_W-1:0]        r_tick;
    logic [CNT_W-1:0]        w_tick_nxt;
    logic [IDX_W-1:0]        r_bit;
    logic [IDX_W-1:0]        w_bit_nxt;
    logic [package_size-1:0] r_shift;
    logic [package_size-1:0] w_shift_nxt;
    logic [package_size-1:0] r_data;
    logic [package_size-1:0] w_data_nxt;
    logic                    r_valid;
    logic                    w_valid_nxt;
    logic                    r_ferr;
    logic                    w_ferr_nxt;
    logic                    r_busy;

    uart_sync2 #(
        .RESET_VALUE(STOP_BIT)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (rx),
        .o_q (w_rx_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_tick  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tick  <= w_tick_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
            r_ferr  <= w_ferr_nxt;
            r_busy  <= (w_state_nxt != IDLE);
        end
    end

    // Leaving STOP at mid-bit lets IDLE catch a back-to-back start edge.
    always_comb begin
        w_state_nxt = r_state;
        w_tick_nxt  = r_tick + 1'b1;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_data_nxt  = r_data;
        w_valid_nxt = 1'b0;
        w_ferr_nxt  = 1'b0;

        case (r_state)
            IDLE: begin
                w_tick_nxt = '0;
                if (w_rx_s == START_BIT) begin
                    w_state_nxt = START;
                end
            end
            START: begin
                if (r_tick == HALF_LAST) begin
                    w_tick_nxt = '0;
                    if (w_rx_s == START_BIT) begin
                        w_state_nxt = DATA;
                        w_bit_nxt   = '0;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            DATA: begin
                if (r_tick == BIT_LAST) begin
                    w_tick_nxt                    = '0;
                    w_shift_nxt                   = r_shift >> 1;
                    w_shift_nxt[package_size-1]   = w_rx_s;
                    if (r_bit == IDX_LAST) begin
                        w_state_nxt = STOP;
                    end else begin
                        w_bit_nxt = r_bit + 1'b1;
                    end
                end
            end
            STOP: begin
                if (r_tick == BIT_LAST) begin
                    w_tick_nxt = '0;
                    if (w_rx_s == STOP_BIT) begin
                        w_data_nxt  = r_shift;
                        w_valid_nxt = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_ferr_nxt  = 1'b1;
                        w_state_nxt = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                w_tick_nxt = '0;
                if (w_rx_s == STOP_BIT) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_tick_nxt  = '0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign data        = r_data;
    assign data_valid  = r_valid;
    assign frame_error = r_ferr;
    assign busy        = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 1600 Hz / 100 baud (16 clocks per bit).
// Frames are built from their bit-level definition and compared against a frame-level reference model.
module tb_uart_rx;

    localparam int FREQ     = 1600;
    localparam int BAUD     = 100;
    localparam int BIT      = FREQ / BAUD;
    localparam int HALF     = BIT / 2;
    localparam int NOMINAL  = HALF + 8 * BIT + BIT;
    localparam int FRAME    = 10 * BIT;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] data;
    logic       data_valid;
    logic       frame_error;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int         validCount     = 0;
    int         ferrCount      = 0;
    int         overlapCount   = 0;
    int         lastValidCycle = 0;
    int         prevValidCycle = 0;
    int         fallCycle      = 0;

    logic [7:0] expData  = 8'h00;
    int         expValid = 0;
    int         expFerr  = 0;

    uart_rx #(
        .transfer_speed(BAUD),
        .package_size  (8),
        .frequency     (FREQ)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .data       (data),
        .data_valid (data_valid),
        .frame_error(frame_error),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (data_valid) begin
            validCount     = validCount + 1;
            prevValidCycle = lastValidCycle;
            lastValidCycle = cyc;
        end
        if (frame_error) ferrCount = ferrCount + 1;
        if (data_valid && frame_error) overlapCount = overlapCount + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkWindow(input string tag, input int obs, input int lo, input int hi);
        checks++;
        assert (obs >= lo && obs <= hi) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic b);
        rx = b;
        waitCycles(BIT);
    endtask

    // Sends one frame; rstBit in 0..7 pulses reset in the middle of that data bit.
    task automatic sendFrame(input logic [7:0] d, input logic stopBit, input int rstBit);
        fallCycle = cyc + 1;
        applyStimulus(1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == rstBit) begin
                rx = d[i];
                waitCycles(HALF);
                rst = 1'b1;
                waitCycles(1);
                checkOutput("rst_mid_data",  {24'b0, data},      32'h0);
                checkOutput("rst_mid_valid", {31'b0, data_valid}, 32'h0);
                checkOutput("rst_mid_ferr",  {31'b0, frame_error}, 32'h0);
                checkOutput("rst_mid_busy",  {31'b0, busy},       32'h0);
                rst = 1'b0;
                waitCycles(BIT - HALF - 1);
            end else begin
                applyStimulus(d[i]);
            end
        end
        applyStimulus(stopBit);
    endtask

    task automatic expectGoodFrame(input string tag, input logic [7:0] d);
        expData  = d;
        expValid = expValid + 1;
        checkOutput({tag, "_data"},  {24'b0, data}, {24'b0, expData});
        checkOutput({tag, "_count"}, 32'(validCount), 32'(expValid));
        checkOutput({tag, "_ferr"},  32'(ferrCount),  32'(expFerr));
        checkWindow({tag, "_latency"}, lastValidCycle - fallCycle, NOMINAL - 2, NOMINAL + 2);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] rnd;
        int         firstValid;

        // 1: reset and idle line
        waitCycles(5);
        checkOutput("reset_data",  {24'b0, data},       32'h0);
        checkOutput("reset_valid", {31'b0, data_valid}, 32'h0);
        checkOutput("reset_busy",  {31'b0, busy},       32'h0);
        rst = 1'b0;
        waitCycles(200);
        checkOutput("idle_data",   {24'b0, data}, 32'h0);
        checkOutput("idle_valid",  32'(validCount), 32'h0);
        checkOutput("idle_ferr",   32'(ferrCount),  32'h0);
        checkOutput("idle_busy",   {31'b0, busy},   32'h0);

        // 2: single frame 0xA5
        sendFrame(8'hA5, 1'b1, -1);
        expectGoodFrame("frame_a5", 8'hA5);
        checkOutput("busy_fall_with_valid", {31'b0, busy}, 32'h0);
        waitCycles(30);
        checkOutput("hold_a5", {24'b0, data}, 32'hA5);

        // 3: back-to-back 0x00 then 0xFF
        sendFrame(8'h00, 1'b1, -1);
        expectGoodFrame("b2b_00", 8'h00);
        firstValid = lastValidCycle;
        sendFrame(8'hFF, 1'b1, -1);
        expectGoodFrame("b2b_ff", 8'hFF);
        checkOutput("b2b_spacing", 32'(lastValidCycle - firstValid), 32'(FRAME));
        waitCycles(20);

        // 4: 4-cycle glitch, then 0x3C
        rx = 1'b0;
        waitCycles(4);
        rx = 1'b1;
        waitCycles(3);
        checkOutput("glitch_busy_high", {31'b0, busy}, 32'h1);
        waitCycles(14);
        checkOutput("glitch_busy_low",  {31'b0, busy}, 32'h0);
        checkOutput("glitch_no_valid",  32'(validCount), 32'(expValid));
        checkOutput("glitch_no_ferr",   32'(ferrCount),  32'(expFerr));
        sendFrame(8'h3C, 1'b1, -1);
        expectGoodFrame("frame_3c", 8'h3C);
        waitCycles(20);

        // 5: framing error on 0x55, line held low, then 0x12
        sendFrame(8'h55, 1'b0, -1);
        waitCycles(50);
        expFerr = expFerr + 1;
        checkOutput("ferr_count",      32'(ferrCount),  32'(expFerr));
        checkOutput("ferr_no_valid",   32'(validCount), 32'(expValid));
        checkOutput("ferr_data_kept",  {24'b0, data},   {24'b0, expData});
        checkOutput("ferr_busy_held",  {31'b0, busy},   32'h1);
        rx = 1'b1;
        waitCycles(10);
        checkOutput("ferr_busy_release", {31'b0, busy}, 32'h0);
        checkOutput("ferr_single_pulse", 32'(ferrCount), 32'(expFerr));
        sendFrame(8'h12, 1'b1, -1);
        expectGoodFrame("frame_12", 8'h12);
        waitCycles(20);

        // 6: reset during bit 4; the tail (bits 4..7 and stop are 1) must stay silent
        sendFrame(8'hF0, 1'b1, 4);
        expData = 8'h00;
        waitCycles(20);
        checkOutput("rst_tail_no_valid", 32'(validCount), 32'(expValid));
        checkOutput("rst_tail_no_ferr",  32'(ferrCount),  32'(expFerr));
        checkOutput("rst_tail_data",     {24'b0, data},   32'h0);
        sendFrame(8'h81, 1'b1, -1);
        expectGoodFrame("frame_81", 8'h81);

        // Random frames with random idle gaps
        for (int n = 0; n < 8; n++) begin
            rnd = 8'($urandom);
            waitCycles($urandom_range(0, 30));
            sendFrame(rnd, 1'b1, -1);
            expectGoodFrame("random", rnd);
        end

        waitCycles(40);
        checkOutput("never_both_strobes", 32'(overlapCount), 32'h0);
        checkOutput("final_valid_total",  32'(validCount),   32'(expValid));
        checkOutput("final_busy",         {31'b0, busy},     32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
